knn_dist_rank: RTL and testbench
================================

KNN_DIST_RANK -- requirements
Module: knn_dist_rank

Interface
REQ-001 Parameter DATA_W, default 32: width of one distance word and one label word; each list entry is 2*DATA_W wide.
REQ-002 Parameter N_elem, default 10: number of entries in the sorted neighbour list (K).
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-low.
REQ-005 Port clear  input  1  synchronous restart of the list.
REQ-006 Port test_pt  input  DATA_W  query point: {x, y}, each a signed DATA_W/2 field, x in the upper half.
REQ-007 Port data_pt  input  DATA_W  training point, same format as test_pt.
REQ-008 Port label  input  DATA_W  class label of data_pt.
REQ-009 Port in_valid / in_ready  input / output  1 / 1  input handshake.
REQ-010 Port mem  input  2*N_elem*DATA_W  current sorted list; entry k at bits [2*DATA_W*(k+1)-1 : 2*DATA_W*k], distance in its upper DATA_W bits, label in its lower DATA_W bits.
REQ-011 Port position  output  DATA_W  insertion index, 0..N_elem.
REQ-012 Port new_value  output  2*DATA_W  {distance, label} to insert.
REQ-013 Port insert  output  1  1 = position < N_elem.
REQ-014 Port fill  output  $clog2(N_elem+1)  number of valid list entries.
REQ-015 Port out_valid / out_ready  output / input  1 / 1  output handshake.

Function
REQ-016 FSM states IDLE, DIST, SCAN, DONE; in_ready SHALL be 1 only in IDLE.
REQ-017 IDLE -> DIST on in_valid & in_ready; test_pt, data_pt and label are registered on that edge.
REQ-018 DIST (1 cycle): dx = x_t - x_d and dy = y_t - y_d in DATA_W/2+1 bits signed; dist = dx*dx + dy*dy, computed at full width.
REQ-019 dist greater than 2^DATA_W - 1 SHALL saturate to all-ones; DIST -> SCAN always, with scan index i = 0.
REQ-020 SCAN examines one entry per cycle: if i == fill, or dist < mem distance[i] (strict unsigned compare), then position = i -> DONE; otherwise i = i + 1.
REQ-021 Ties SHALL place the new entry after existing equal distances.
REQ-022 Latency: out_valid SHALL rise on rising edge position+2 counted from the accepting edge.
REQ-023 DONE: out_valid = 1; position, new_value, insert held stable until out_valid & out_ready, then -> IDLE.
REQ-024 fill SHALL increment by 1 on the output handshake when fill < N_elem and insert = 1, and SHALL saturate at N_elem.
REQ-025 With fill == N_elem and no hit: position = N_elem, insert = 0, fill unchanged (candidate discarded).
REQ-026 clear SHALL have priority over all other inputs: fill = 0, state = IDLE, out_valid = 0, even mid-DIST, SCAN or DONE; an in_valid in the same cycle SHALL be ignored.
REQ-027 mem SHALL be read only in SCAN; the consumer holds mem stable from the accepting edge to the output handshake.
REQ-028 Entries with index >= fill SHALL never be compared.

Reset
REQ-029 While rst = 0: state IDLE, fill 0, out_valid 0, position 0, new_value 0, insert 0, scan index 0; in_valid ignored.
REQ-030 rst assertion mid-operation SHALL abort the operation immediately; in_ready = 1 on the first cycle after release.

Verification
REQ-031 Reset, fill 0, test (0,0), data (3,4), label 7 -> dist 25, position 0, new_value {25,7}, insert 1, out_valid 2 edges after accept, fill 1 after the handshake.
REQ-032 fill 3, mem distances [10,20,30], new dist 25 -> position 2, out_valid 4 edges after accept; new dist 20 -> position 2 (tie rule).
REQ-033 fill 10, all distances <= 5, new dist 100 -> position 10, insert 0, out_valid 12 edges after accept, fill stays 10.
REQ-034 Test (-32768,-32768), data (32767,32767) -> new_value distance 0xFFFFFFFF (saturated), position = fill.
REQ-035 out_ready held low 5 cycles in DONE -> outputs stable and in_ready 0 throughout; handshake on the 6th cycle -> IDLE on the next edge.
REQ-036 clear pulsed during SCAN with fill 4 -> next cycle: IDLE, out_valid 0, fill 0; rst pulsed mid-DIST -> all reset values, no output produced.

Source files
------------

// File: rtl/knn_dist_rank.sv
// knn_dist_rank: squared-distance ranker that finds the insertion slot of a new point in a sorted K-NN list
// Ports: clk/rst (async active-low) clock and reset; clear synchronous list restart;
//   test_pt/data_pt {x,y} signed halves, label class tag, in_valid/in_ready input handshake;
//   mem sorted list {dist,label} per entry; position/new_value/insert insertion result;
//   fill valid entry count; out_valid/out_ready output handshake.
module knn_dist_rank #(
    parameter int DATA_W = 32,
    parameter int N_elem = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic [DATA_W-1:0]          test_pt,
    input  logic [DATA_W-1:0]          data_pt,
    input  logic [DATA_W-1:0]          label,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2*N_elem*DATA_W-1:0] mem,
    output logic [DATA_W-1:0]          position,
    output logic [2*DATA_W-1:0]        new_value,
    output logic                       insert,
    output logic [$clog2(N_elem+1)-1:0] fill,
    output logic                       out_valid,
    input  logic                       out_ready
);
    localparam int HW  = DATA_W / 2;
    localparam int SW  = DATA_W + 3;
    localparam int FW  = $clog2(N_elem + 1);
    localparam int ISZ = 2 ** FW;

    typedef enum logic [1:0] {IDLE, DIST, SCAN, DONE} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] test_q, test_d, data_q, data_d, label_q, label_d;
    logic [DATA_W-1:0] dist_q, dist_d, pos_q, pos_d;
    logic [FW-1:0]     idx_q, idx_d, fill_q, fill_d;
    logic              ins_q, ins_d;
    logic signed [HW:0]   dx, dy;
    logic signed [SW-1:0] dxe, dye;
    logic [SW-1:0]     sq;
    logic              hit;
    // Distance view of the list padded to a power of two so the scan index never leaves the array
    logic [DATA_W-1:0] md [ISZ];

    for (genvar g = 0; g < ISZ; g++) begin : g_md
        if (g < N_elem) begin : g_v
            logic unused_l;
            assign md[g]    = mem[2*DATA_W*g+DATA_W +: DATA_W];
            assign unused_l = ^mem[2*DATA_W*g +: DATA_W];
        end else begin : g_z
            assign md[g] = '0;
        end
    end

    assign dx  = {test_q[DATA_W-1], test_q[DATA_W-1:HW]} - {data_q[DATA_W-1], data_q[DATA_W-1:HW]};
    assign dy  = {test_q[HW-1], test_q[HW-1:0]} - {data_q[HW-1], data_q[HW-1:0]};
    assign dxe = SW'(dx);
    assign dye = SW'(dy);
    assign sq  = dxe * dxe + dye * dye;
    // Stopping at idx == fill keeps entries beyond the valid region out of the compare
    assign hit = idx_q == fill_q || dist_q < md[idx_q];

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign position  = pos_q;
    assign new_value = {dist_q, label_q};
    assign insert    = ins_q;
    assign fill      = fill_q;

    always_comb begin
        state_d = state_q;
        test_d  = test_q;
        data_d  = data_q;
        label_d = label_q;
        dist_d  = dist_q;
        pos_d   = pos_q;
        idx_d   = idx_q;
        fill_d  = fill_q;
        ins_d   = ins_q;
        if (clear) begin
            state_d = IDLE;
            fill_d  = '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    state_d = DIST;
                    test_d  = test_pt;
                    data_d  = data_pt;
                    label_d = label;
                end
                DIST: begin
                    dist_d  = |sq[SW-1:DATA_W] ? '1 : sq[DATA_W-1:0];
                    idx_d   = '0;
                    state_d = SCAN;
                end
                SCAN: if (hit) begin
                    pos_d   = DATA_W'(idx_q);
                    ins_d   = idx_q < FW'(N_elem);
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + FW'(1);
                end
                DONE: if (out_ready) begin
                    state_d = IDLE;
                    fill_d  = ins_q && fill_q < FW'(N_elem) ? fill_q + FW'(1) : fill_q;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            test_q  <= '0;
            data_q  <= '0;
            label_q <= '0;
            dist_q  <= '0;
            pos_q   <= '0;
            idx_q   <= '0;
            fill_q  <= '0;
            ins_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            test_q  <= test_d;
            data_q  <= data_d;
            label_q <= label_d;
            dist_q  <= dist_d;
            pos_q   <= pos_d;
            idx_q   <= idx_d;
            fill_q  <= fill_d;
            ins_q   <= ins_d;
        end
    end
endmodule

// File: tb/tb_knn_dist_rank.sv
// tb_knn_dist_rank: scoreboard bench for knn_dist_rank against an arithmetic sorted-list model
module tb_knn_dist_rank;
    localparam int DW = 32;
    localparam int K  = 10;
    localparam int FW = $clog2(K + 1);

    typedef struct {
        int          pos;
        logic [63:0] nv;
        bit          ins;
        int          lat;
        int          acc;
    } exp_t;

    logic              clk = 1'b0, rst = 1'b0, clear = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [DW-1:0]     test_pt = '0, data_pt = '0, label = '0;
    logic              in_ready, insert, out_valid;
    logic [2*K*DW-1:0] mem;
    logic [DW-1:0]     position;
    logic [2*DW-1:0]   new_value;
    logic [FW-1:0]     fill;
    logic [DW-1:0]     dl [K];
    logic [DW-1:0]     ll [K];
    int                mfill = 0;
    int                total = 0, bad = 0, cyc = 0;
    exp_t              q[$];
    bit                seen = 0;

    knn_dist_rank #(.DATA_W(DW), .N_elem(K)) dut (
        .clk(clk), .rst(rst), .clear(clear), .test_pt(test_pt), .data_pt(data_pt),
        .label(label), .in_valid(in_valid), .in_ready(in_ready), .mem(mem),
        .position(position), .new_value(new_value), .insert(insert), .fill(fill),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        mem = '0;
        for (int k = 0; k < K; k++) mem[2*DW*k +: 2*DW] = {dl[k], ll[k]};
    end

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] pt(int x, int y);
        return {x[15:0], y[15:0]};
    endfunction

    function automatic logic [31:0] mdist(logic [31:0] t, logic [31:0] d);
        longint dx, dy, s;
        dx = longint'($signed(t[31:16])) - longint'($signed(d[31:16]));
        dy = longint'($signed(t[15:0])) - longint'($signed(d[15:0]));
        s  = dx * dx + dy * dy;
        return s > 64'hFFFF_FFFF ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    // Slot = number of valid entries whose distance is <= the new one (ties go after)
    function automatic int mpos(logic [31:0] nd);
        int p = 0;
        for (int k = 0; k < mfill; k++) if (dl[k] <= nd) p++;
        return p;
    endfunction

    task automatic model_clear();
        mfill = 0;
        for (int k = 0; k < K; k++) begin
            dl[k] = '0;
            ll[k] = '0;
        end
    endtask

    task automatic txn(input logic [31:0] t, input logic [31:0] d, input logic [31:0] l, input int hold);
        exp_t        e;
        logic [31:0] nd;
        int          w;
        nd    = mdist(t, d);
        e.pos = mpos(nd);
        e.nv  = {nd, l};
        e.ins = e.pos < K;
        e.lat = e.pos + 2;
        e.acc = cyc;
        q.push_back(e);
        chk("in_ready_idle", in_ready, 1);
        test_pt  = t;
        data_pt  = d;
        label    = l;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 40) begin
            @(posedge clk); #1;
            w++;
        end
        chk("out_valid_wait", out_valid, 1);
        if (!out_valid) begin
            if (q.size() > 0) void'(q.pop_front());
            return;
        end
        repeat (hold) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        if (e.ins) begin
            for (int k = K - 1; k > e.pos; k--) begin
                dl[k] = dl[k-1];
                ll[k] = ll[k-1];
            end
            dl[e.pos] = nd;
            ll[e.pos] = l;
            if (mfill < K) mfill++;
        end
        chk("fill_after_hs", fill, mfill);
        chk("idle_after_hs", {in_ready, out_valid}, 2'b10);
    endtask

    task automatic rand_txn(input int span);
        txn(pt(int'($urandom_range(2*span)) - span, int'($urandom_range(2*span)) - span),
            pt(int'($urandom_range(2*span)) - span, int'($urandom_range(2*span)) - span),
            $urandom, int'($urandom_range(3)));
    endtask

    always @(negedge clk) begin
        if (rst && out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_out_valid", out_valid, 0);
            end else begin
                if (!seen) chk("latency", cyc - q[0].acc - 1, q[0].lat);
                seen = 1;
                chk("position", position, q[0].pos);
                chk("new_value", new_value, q[0].nv);
                chk("insert", insert, q[0].ins);
                chk("in_ready_busy", in_ready, 0);
                if (out_ready) begin
                    void'(q.pop_front());
                    seen = 0;
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_fill", fill, 0);
        chk("rst_position", position, 0);
        chk("rst_new_value", new_value, 0);
        chk("rst_insert", insert, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", in_ready, 1);
        txn(pt(0, 0), pt(3, 4), 32'd7, 0);
        chk("first_fill", fill, 1);
        txn(pt(-32768, -32768), pt(32767, 32767), 32'd9, 2);
        txn(pt(5, -3), pt(-2, 6), 32'd11, 5);
        for (int i = 0; i < 20; i++) rand_txn(i < 16 ? 6 : 300);
        for (int k = 0; k < K; k++) dl[k] = 32'(k / 2);
        txn(pt(0, 0), pt(6, 8), 32'd3, 1);
        chk("full_fill", fill, K);

        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        model_clear();
        chk("clear_fill", fill, 0);
        for (int i = 0; i < 3; i++) rand_txn(5);
        dl[0] = 32'd10;
        dl[1] = 32'd20;
        dl[2] = 32'd30;
        txn(pt(0, 0), pt(3, 4), 32'd25, 0);
        txn(pt(0, 0), pt(2, 4), 32'd20, 0);

        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        model_clear();
        for (int i = 0; i < 4; i++) rand_txn(5);
        for (int k = 0; k < 4; k++) dl[k] = 32'(k + 1);
        chk("scan_clear_fill_before", fill, 4);
        test_pt  = pt(0, 0);
        data_pt  = pt(3, 4);
        in_valid = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        clear = 1'b1;
        @(posedge clk); #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        model_clear();
        chk("scan_clear_state", {in_ready, out_valid}, 2'b10);
        chk("scan_clear_fill", fill, 0);
        repeat (8) begin
            @(posedge clk); #1;
        end
        chk("scan_clear_quiet", {in_ready, out_valid}, 2'b10);

        txn(pt(1, 1), pt(2, 2), 32'd5, 0);
        test_pt  = pt(0, 0);
        data_pt  = pt(1, 0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst      = 1'b0;
        #1;
        model_clear();
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_fill", fill, 0);
        chk("midrst_position", position, 0);
        chk("midrst_new_value", new_value, 0);
        chk("midrst_insert", insert, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_release_ready", in_ready, 1);
        repeat (10) begin
            @(posedge clk); #1;
        end
        chk("midrst_no_output", out_valid, 0);
        txn(pt(-4, 2), pt(0, -1), 32'd42, 1);
        repeat (3) @(posedge clk);
        chk("scoreboard_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
